// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a valid/ready handshake and holds
// the instruction for the control unit until Retire, then steps to the next PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      Instr,
  output logic             InstrValid,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  input  logic             Retire,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             RegtoPC,
  input  logic             Zero,
  input  logic [31:0]      SignImm,
  input  logic [31:0]      RegPC,
  output logic             AddrErr,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [1:0] {StRst, StFetch, StHold} state_e;

  state_e           state_q;
  logic [31:0]      pc_q;
  logic [31:0]      instr_q;
  logic             req_q;
  logic             valid_q;
  logic             addr_err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0] pc_plus4;
  logic [31:0] jump_tgt;
  logic [31:0] br_tgt;
  logic [31:0] next_pc;
  logic        jr_misaligned;

  // jr drives Jump as well, so RegtoPC must win over Jump.
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    jump_tgt      = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    br_tgt        = pc_plus4 + (SignImm << 2);
    jr_misaligned = RegtoPC && (RegPC[1:0] != 2'b00);
    if (RegtoPC) begin
      next_pc = {RegPC[31:2], 2'b00};
    end else if (Jump) begin
      next_pc = jump_tgt;
    end else if (Branch && Zero) begin
      next_pc = br_tgt;
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StRst;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        StRst: begin
          state_q <= StFetch;
          req_q   <= 1'b1;
        end
        StFetch: begin
          // The request stays up until memory takes it; Retire has no effect here.
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state_q <= StHold;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (Retire) begin
            pc_q    <= next_pc;
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= StFetch;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            if (jr_misaligned) begin
              addr_err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StRst;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign PC         = pc_q;
  assign PCPlus4    = pc_plus4;
  assign AddrErr    = addr_err_q;
  assign InstrCount = cnt_q;

endmodule
